// File: rtl/my_package_pkg.sv
// Shared constants and state encoding for the split {msb,lsb} bunch counter tracker.
package my_package_pkg;

  localparam logic [11:0] LSB_CNT_MAX = 12'd3563;
  localparam logic        ZERO        = 1'b0;
  localparam logic        ONE         = 1'b1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNC     = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  function automatic logic lsb_in_range(input logic [11:0] lsb);
    return (lsb <= LSB_CNT_MAX);
  endfunction

endpackage

// File: rtl/split_cnt_succ.sv
// Combinational successor of a split {msb,lsb} count; msb wraps modulo 8.
module split_cnt_succ
  import my_package_pkg::*;
(
  input  logic [2:0]  msb,
  input  logic [11:0] lsb,
  output logic [2:0]  succ_msb,
  output logic [11:0] succ_lsb
);

  // lsb rolls over at LSB_CNT_MAX and carries into msb
  always_comb begin
    if (lsb == LSB_CNT_MAX) begin
      succ_lsb = 12'd0;
      succ_msb = msb + 3'd1;
    end else begin
      succ_lsb = lsb + 12'd1;
      succ_msb = msb;
    end
  end

endmodule

// File: rtl/split_cnt_checker.sv
// Receive-side lock/flywheel tracker for the split bunch counter with
// mismatch, range-error and saturating error-count reporting.
module split_cnt_checker
  import my_package_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cnt_valid_i,
  input  logic [11:0]          lsb_cnt_i,
  input  logic [2:0]           msb_cnt_i,
  input  logic                 clear_err_i,
  output logic                 locked_o,
  output logic                 mismatch_o,
  output logic                 range_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [11:0]          exp_lsb_cnt_o,
  output logic [2:0]           exp_msb_cnt_o
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

  state_t               state_r, state_nxt_s;
  logic [2:0]           exp_msb_r, exp_msb_nxt_s;
  logic [11:0]          exp_lsb_r, exp_lsb_nxt_s;
  logic [MATCH_W-1:0]   match_cnt_r, match_cnt_nxt_s, match_inc_s;
  logic [MISS_W-1:0]    miss_cnt_r, miss_cnt_nxt_s, miss_inc_s;
  logic [ERR_CNT_W-1:0] err_cnt_r, err_cnt_nxt_s, err_inc_s;
  logic                 mismatch_r, mismatch_nxt_s;
  logic                 range_err_r, range_err_nxt_s;
  logic                 locked_r;

  logic [2:0]           succ_exp_msb_s, succ_word_msb_s;
  logic [11:0]          succ_exp_lsb_s, succ_word_lsb_s;
  logic                 in_range_s, word_match_s;

  split_cnt_succ u_succ_exp (
    .msb      (exp_msb_r),
    .lsb      (exp_lsb_r),
    .succ_msb (succ_exp_msb_s),
    .succ_lsb (succ_exp_lsb_s)
  );

  split_cnt_succ u_succ_word (
    .msb      (msb_cnt_i),
    .lsb      (lsb_cnt_i),
    .succ_msb (succ_word_msb_s),
    .succ_lsb (succ_word_lsb_s)
  );

  assign in_range_s   = lsb_in_range(lsb_cnt_i);
  assign word_match_s = ({msb_cnt_i, lsb_cnt_i} == {exp_msb_r, exp_lsb_r});
  assign match_inc_s  = match_cnt_r + MATCH_W'(1'b1);
  assign miss_inc_s   = miss_cnt_r + MISS_W'(1'b1);

  // Saturating error increment
  always_comb begin
    if (err_cnt_r == {ERR_CNT_W{1'b1}}) begin
      err_inc_s = err_cnt_r;
    end else begin
      err_inc_s = err_cnt_r + ERR_CNT_W'(1'b1);
    end
  end

  // Next-state and next-output decode; nothing advances without a valid word
  always_comb begin
    state_nxt_s     = state_r;
    exp_msb_nxt_s   = exp_msb_r;
    exp_lsb_nxt_s   = exp_lsb_r;
    match_cnt_nxt_s = match_cnt_r;
    miss_cnt_nxt_s  = miss_cnt_r;
    err_cnt_nxt_s   = err_cnt_r;
    mismatch_nxt_s  = ZERO;
    range_err_nxt_s = ZERO;

    if (cnt_valid_i) begin
      range_err_nxt_s = ~in_range_s;
      case (state_r)
        UNLOCKED: begin
          if (in_range_s) begin
            exp_msb_nxt_s   = succ_word_msb_s;
            exp_lsb_nxt_s   = succ_word_lsb_s;
            match_cnt_nxt_s = MATCH_W'(1'b1);
            state_nxt_s     = SYNC;
          end else begin
            state_nxt_s     = UNLOCKED;
          end
        end
        SYNC: begin
          if (!in_range_s) begin
            match_cnt_nxt_s = {MATCH_W{1'b0}};
            state_nxt_s     = UNLOCKED;
          end else if (word_match_s) begin
            exp_msb_nxt_s   = succ_exp_msb_s;
            exp_lsb_nxt_s   = succ_exp_lsb_s;
            match_cnt_nxt_s = match_inc_s;
            if (match_inc_s >= MATCH_W'(LOCK_CNT)) begin
              miss_cnt_nxt_s = {MISS_W{1'b0}};
              state_nxt_s    = LOCKED;
            end else begin
              state_nxt_s    = SYNC;
            end
          end else begin
            exp_msb_nxt_s   = succ_word_msb_s;
            exp_lsb_nxt_s   = succ_word_lsb_s;
            match_cnt_nxt_s = MATCH_W'(1'b1);
          end
        end
        LOCKED: begin
          // Flywheel: expected advances whether or not the word agrees
          exp_msb_nxt_s = succ_exp_msb_s;
          exp_lsb_nxt_s = succ_exp_lsb_s;
          if (word_match_s) begin
            miss_cnt_nxt_s = {MISS_W{1'b0}};
          end else begin
            mismatch_nxt_s = ONE;
            err_cnt_nxt_s  = err_inc_s;
            if (miss_inc_s >= MISS_W'(LOSS_CNT)) begin
              miss_cnt_nxt_s  = {MISS_W{1'b0}};
              match_cnt_nxt_s = {MATCH_W{1'b0}};
              state_nxt_s     = UNLOCKED;
            end else begin
              miss_cnt_nxt_s  = miss_inc_s;
            end
          end
        end
        default: begin
          state_nxt_s = UNLOCKED;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end

    if (clear_err_i) begin
      err_cnt_nxt_s = {ERR_CNT_W{1'b0}};
    end else begin
      err_cnt_nxt_s = err_cnt_nxt_s;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= UNLOCKED;
      exp_msb_r   <= 3'd0;
      exp_lsb_r   <= 12'd0;
      match_cnt_r <= {MATCH_W{1'b0}};
      miss_cnt_r  <= {MISS_W{1'b0}};
      err_cnt_r   <= {ERR_CNT_W{1'b0}};
      mismatch_r  <= 1'b0;
      range_err_r <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      exp_msb_r   <= exp_msb_nxt_s;
      exp_lsb_r   <= exp_lsb_nxt_s;
      match_cnt_r <= match_cnt_nxt_s;
      miss_cnt_r  <= miss_cnt_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      mismatch_r  <= mismatch_nxt_s;
      range_err_r <= range_err_nxt_s;
      locked_r    <= (state_nxt_s == LOCKED);
    end
  end

  assign locked_o      = locked_r;
  assign mismatch_o    = mismatch_r;
  assign range_err_o   = range_err_r;
  assign err_cnt_o     = err_cnt_r;
  assign exp_lsb_cnt_o = exp_lsb_r;
  assign exp_msb_cnt_o = exp_msb_r;

endmodule

// File: tb/tb_split_cnt_checker.sv
// Scoreboard bench for split_cnt_checker: the driver queues the expected
// post-edge outputs of every cycle it drives, the monitor pops and compares.
module tb_split_cnt_checker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cnt_valid_i = 1'b0;
  logic [11:0] lsb_cnt_i = 12'd0;
  logic [2:0]  msb_cnt_i = 3'd0;
  logic        clear_err_i = 1'b0;
  logic        locked_o, mismatch_o, range_err_o;
  logic [7:0]  err_cnt_o;
  logic [11:0] exp_lsb_cnt_o;
  logic [2:0]  exp_msb_cnt_o;

  typedef struct packed {
    logic        lock;
    logic        mis;
    logic        rng;
    logic [7:0]  err;
    logic [2:0]  msb;
    logic [11:0] lsb;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  split_cnt_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_CNT_W(8)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cnt_valid_i   (cnt_valid_i),
    .lsb_cnt_i     (lsb_cnt_i),
    .msb_cnt_i     (msb_cnt_i),
    .clear_err_i   (clear_err_i),
    .locked_o      (locked_o),
    .mismatch_o    (mismatch_o),
    .range_err_o   (range_err_o),
    .err_cnt_o     (err_cnt_o),
    .exp_lsb_cnt_o (exp_lsb_cnt_o),
    .exp_msb_cnt_o (exp_msb_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t mk(input int lk, input int ms, input int rg, input int er,
                              input int em, input int el);
    exp_t e;
    e.lock = 1'(lk);
    e.mis  = 1'(ms);
    e.rng  = 1'(rg);
    e.err  = 8'(er);
    e.msb  = 3'(em);
    e.lsb  = 12'(el);
    return e;
  endfunction

  task automatic cyc(input string tag, input logic v, input logic r, input logic c,
                     input int m, input int l, input exp_t e);
    @(negedge clk_i);
    cnt_valid_i = v;
    rst_i       = r;
    clear_err_i = c;
    msb_cnt_i   = 3'(m);
    lsb_cnt_i   = 12'(l);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic w(input string tag, input int m, input int l, input exp_t e);
    cyc(tag, 1'b1, 1'b0, 1'b0, m, l, e);
  endtask

  task automatic rst1(input string tag, input logic v, input int m, input int l);
    cyc(tag, v, 1'b1, 1'b0, m, l, mk(0, 0, 0, 0, 0, 0));
  endtask

  // Monitor: compare outputs 1 time unit after each rising edge
  initial begin
    exp_t  e;
    exp_t  a;
    string t;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        a = {locked_o, mismatch_o, range_err_o, err_cnt_o, exp_msb_cnt_o, exp_lsb_cnt_o};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got lock=%0d mis=%0d rng=%0d err=%0d exp=(%0d,%0d) want lock=%0d mis=%0d rng=%0d err=%0d exp=(%0d,%0d)",
                   t, a.lock, a.mis, a.rng, a.err, a.msb, a.lsb,
                   e.lock, e.mis, e.rng, e.err, e.msb, e.lsb);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s;
    // Reset state
    rst1("reset_a", 1'b0, 0, 0);
    rst1("reset_b", 1'b0, 0, 0);

    // Lock acquisition
    w("lock1", 0, 10, mk(0, 0, 0, 0, 0, 11));
    w("lock2", 0, 11, mk(0, 0, 0, 0, 0, 12));
    w("lock3", 0, 12, mk(0, 0, 0, 0, 0, 13));
    w("lock4", 0, 13, mk(1, 0, 0, 0, 0, 14));

    // Out-of-range words while locked drop lock on the third
    w("oor_lk1", 0, 4000, mk(1, 1, 1, 1, 0, 15));
    w("oor_lk2", 0, 4000, mk(1, 1, 1, 2, 0, 16));
    w("oor_lk3", 0, 4000, mk(0, 1, 1, 3, 0, 17));
    w("oor_unl", 0, 4000, mk(0, 0, 1, 3, 0, 17));
    w("sync_load", 0, 50, mk(0, 0, 0, 3, 0, 51));
    w("sync_reload", 0, 60, mk(0, 0, 0, 3, 0, 61));
    w("sync_oor", 0, 4000, mk(0, 0, 1, 3, 0, 61));
    cyc("idle_hold", 1'b0, 1'b0, 1'b0, 0, 4000, mk(0, 0, 0, 3, 0, 61));
    cyc("clr_idle", 1'b0, 1'b0, 1'b1, 0, 0, mk(0, 0, 0, 0, 0, 61));
    w("unl_load", 0, 62, mk(0, 0, 0, 0, 0, 63));

    // Wrap of lsb into msb
    rst1("rst_wrap", 1'b0, 0, 0);
    w("wlock1", 2, 3559, mk(0, 0, 0, 0, 2, 3560));
    w("wlock2", 2, 3560, mk(0, 0, 0, 0, 2, 3561));
    w("wlock3", 2, 3561, mk(0, 0, 0, 0, 2, 3562));
    w("wlock4", 2, 3562, mk(1, 0, 0, 0, 2, 3563));
    w("wrap_2", 2, 3563, mk(1, 0, 0, 0, 3, 0));
    w("wrap_3", 3, 0, mk(1, 0, 0, 0, 3, 1));

    // Reset mid-lock with a valid word present, then re-lock needs 4 words
    rst1("rst_mid", 1'b1, 3, 1);
    w("rlock1", 7, 3559, mk(0, 0, 0, 0, 7, 3560));
    w("rlock2", 7, 3560, mk(0, 0, 0, 0, 7, 3561));
    w("rlock3", 7, 3561, mk(0, 0, 0, 0, 7, 3562));
    w("rlock4", 7, 3562, mk(1, 0, 0, 0, 7, 3563));
    w("wrap_7", 7, 3563, mk(1, 0, 0, 0, 0, 0));
    w("wrap_0", 0, 0, mk(1, 0, 0, 0, 0, 1));

    // Single glitch, then two consecutive misses stay locked
    rst1("rst_glitch", 1'b0, 0, 0);
    w("glock1", 1, 96, mk(0, 0, 0, 0, 1, 97));
    w("glock2", 1, 97, mk(0, 0, 0, 0, 1, 98));
    w("glock3", 1, 98, mk(0, 0, 0, 0, 1, 99));
    w("glock4", 1, 99, mk(1, 0, 0, 0, 1, 100));
    w("glitch", 1, 555, mk(1, 1, 0, 1, 1, 101));
    w("glitch_ok", 1, 101, mk(1, 0, 0, 1, 1, 102));
    w("miss_a", 1, 0, mk(1, 1, 0, 2, 1, 103));
    w("miss_b", 1, 0, mk(1, 1, 0, 3, 1, 104));
    w("miss_rec", 1, 104, mk(1, 0, 0, 3, 1, 105));

    // Saturation: alternate mismatch/match to stay locked for 256 mismatches
    rst1("rst_sat", 1'b0, 0, 0);
    w("slock1", 0, 0, mk(0, 0, 0, 0, 0, 1));
    w("slock2", 0, 1, mk(0, 0, 0, 0, 0, 2));
    w("slock3", 0, 2, mk(0, 0, 0, 0, 0, 3));
    w("slock4", 0, 3, mk(1, 0, 0, 0, 0, 4));
    for (int k = 0; k < 256; k++) begin
      s = (k + 1 > 255) ? 255 : k + 1;
      w("sat_mis", 5, 2000, mk(1, 1, 0, s, 0, 5 + 2 * k));
      w("sat_match", 0, 5 + 2 * k, mk(1, 0, 0, s, 0, 6 + 2 * k));
    end
    cyc("clr_mis", 1'b1, 1'b0, 1'b1, 5, 2000, mk(1, 1, 0, 0, 0, 517));
    w("post_clr", 5, 2000, mk(1, 1, 0, 1, 0, 518));
    w("post_match", 0, 518, mk(1, 0, 0, 1, 0, 519));

    @(negedge clk_i);
    cnt_valid_i = 1'b0;
    clear_err_i = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk_i);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
